update_scheduler: RTL and testbench

- Buffers incoming edge-weight updates (src vertex, dst vertex, weight) from the host side in a small FIFO.
- Issues the updates one at a time to the graph-update/Bellman-Ford/cycle-detect container by sequencing its reset/done handshake.
- Sits between the host register interface and the container; owns the container's source-vertex configuration and a watchdog for hung runs.

---
 rtl/update_scheduler.sv | 153 +++++++++++++++
 tb/tb_update_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/update_scheduler.sv
// update_scheduler: queues host edge-weight updates and issues them one at a
// time to the graph-update / Bellman-Ford / cycle-detect container, driving
// its reset/done handshake and aborting runs that hang past TIMEOUT cycles.
module update_scheduler #(
    parameter int IDX_W    = 8,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [IDX_W-1:0]            upd_src,
    input  logic [IDX_W-1:0]            upd_dst,
    input  logic [WEIGHT_W-1:0]         upd_e,
    input  logic                        cfg_src_we,
    input  logic [IDX_W-1:0]            cfg_src,
    output logic [IDX_W-1:0]            src,
    output logic [IDX_W-1:0]            u_src,
    output logic [IDX_W-1:0]            u_dst,
    output logic [WEIGHT_W-1:0]         u_e,
    output logic                        container_reset,
    input  logic                        container_done,
    output logic                        busy,
    output logic                        run_done,
    output logic                        timeout_err,
    input  logic                        err_clr,
    output logic [15:0]                 run_count,
    output logic [$clog2(DEPTH):0]      fifo_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [IDX_W-1:0]    s;
        logic [IDX_W-1:0]    d;
        logic [WEIGHT_W-1:0] e;
    } upd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_COMPLETE, S_ABORT
    } state_t;

    state_t            state_q, state_d;
    upd_t              mem [DEPTH];
    upd_t              head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [WD_W-1:0]   wd_q;
    logic              ready_en;
    logic              push, pop;
    logic              cr_d, done_d, abort_d, load_d;

    // ready stays low through reset and the release cycle edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign upd_ready  = ready_en && (level != LVL_FULL);
    assign push       = upd_valid && upd_ready;
    assign pop        = ((state_q == S_COMPLETE) || (state_q == S_ABORT)) && (level != '0);
    assign head       = mem[rd_ptr];
    assign fifo_level = level;
    assign busy       = (state_q != S_IDLE);

    // FIFO storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{s: upd_src, d: upd_dst, e: upd_e};
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // next-state: done beats the watchdog when both land in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (level != '0) state_d = S_LAUNCH;
            S_LAUNCH:   state_d = S_RUN;
            S_RUN: begin
                if (container_done)       state_d = S_COMPLETE;
                else if (wd_q == WD_LAST) state_d = S_ABORT;
            end
            S_COMPLETE: state_d = S_IDLE;
            S_ABORT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // output decode from the upcoming state so outputs register in step with it
    always_comb begin
        cr_d    = (state_d != S_RUN);
        done_d  = (state_d == S_COMPLETE);
        abort_d = (state_d == S_ABORT);
        load_d  = (state_d == S_LAUNCH);
    end

    // registered outputs, watchdog and source-vertex config
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            container_reset <= 1'b1;
            run_done        <= 1'b0;
            timeout_err     <= 1'b0;
            run_count       <= '0;
            u_src           <= '0;
            u_dst           <= '0;
            u_e             <= '0;
            src             <= '0;
            wd_q            <= '0;
        end else begin
            container_reset <= cr_d;
            run_done        <= done_d;
            if (done_d) run_count <= run_count + 16'd1;
            // a new abort wins over a coincident clear
            if (abort_d)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
            if (load_d) begin
                u_src <= head.s;
                u_dst <= head.d;
                u_e   <= head.e;
            end
            // src only moves between runs so the container sees it stable
            if (cfg_src_we && (state_q == S_IDLE)) src <= cfg_src;
            if (state_q == S_LAUNCH)   wd_q <= '0;
            else if (state_q == S_RUN) wd_q <= wd_q + WD_W'(1);
        end
    end
endmodule

// File: tb/tb_update_scheduler.sv
// Scoreboard bench for update_scheduler: stimulus queues the expected issue
// record (operands, run length, completion vs abort); a negedge monitor pops
// and checks it at each launch and run end.
module tb_update_scheduler;
    localparam int IDX_W = 8, WEIGHT_W = 32, DEPTH = 8, TIMEOUT = 20;

    logic clk = 1'b0, reset_n = 1'b0;
    logic upd_valid = 1'b0, cfg_src_we = 1'b0, err_clr = 1'b0;
    logic [IDX_W-1:0] upd_src = '0, upd_dst = '0, cfg_src = '0;
    logic [WEIGHT_W-1:0] upd_e = '0;
    logic upd_ready, container_reset, container_done, busy, run_done, timeout_err;
    logic [IDX_W-1:0] src, u_src, u_dst;
    logic [WEIGHT_W-1:0] u_e;
    logic [15:0] run_count;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0, failures = 0;
    int done_n = 1000;
    int run_cyc = 0;

    typedef struct {
        logic [IDX_W-1:0]    s;
        logic [IDX_W-1:0]    d;
        logic [WEIGHT_W-1:0] e;
        int                  len;
        bit                  ok;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    update_scheduler #(.IDX_W(IDX_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_src(upd_src), .upd_dst(upd_dst), .upd_e(upd_e),
        .cfg_src_we(cfg_src_we), .cfg_src(cfg_src), .src(src),
        .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
        .container_reset(container_reset), .container_done(container_done),
        .busy(busy), .run_done(run_done), .timeout_err(timeout_err), .err_clr(err_clr),
        .run_count(run_count), .fifo_level(fifo_level)
    );

    // container model: done rises in the done_n-th cycle with reset released, sticky
    always @(posedge clk) begin
        if (container_reset) run_cyc <= 0;
        else                 run_cyc <= run_cyc + 1;
    end
    assign container_done = !container_reset && (run_cyc >= done_n - 1);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // offer an update for the next edge and record what must be issued
    task automatic offer(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d,
                         input logic [WEIGHT_W-1:0] e, input int len, input bit ok);
        exp_t x;
        upd_valid = 1'b1; upd_src = s; upd_dst = d; upd_e = e;
        x.s = s; x.d = d; x.e = e; x.len = len; x.ok = ok;
        exp_q.push_back(x);
        tick();
    endtask

    // monitor: checks issued operands at run start, length/outcome at run end
    initial begin
        bit in_run;
        bit have;
        int len;
        exp_t cur;
        in_run = 0; have = 0; len = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_run = 0;
                have = 0;
            end else if (!container_reset) begin
                if (!in_run) begin
                    in_run = 1;
                    len = 1;
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_launch u_src=%0h u_dst=%0h u_e=%0h", u_src, u_dst, u_e);
                        have = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1;
                        chk("issue_u_src", u_src, cur.s);
                        chk("issue_u_dst", u_dst, cur.d);
                        chk("issue_u_e", u_e, cur.e);
                    end
                end else begin
                    len++;
                end
            end else if (in_run) begin
                in_run = 0;
                if (have) begin
                    chk("run_low_cycles", len, cur.len);
                    chk("run_done_at_end", run_done, cur.ok);
                    if (!cur.ok) chk("timeout_err_at_abort", timeout_err, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n, rc;
        // reset state while reset_n is held low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_container_reset", container_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_run_count", run_count, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_u_bus", {u_src, u_dst, u_e}, 0);
        chk("rst_src", src, 0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_release", upd_ready, 1);

        // single update, done in the 10th RUN cycle
        done_n = 10;
        offer(8'd3, 8'd5, 32'd100, 10, 1);
        upd_valid = 1'b0;
        n = 0;
        while (!run_done && n < 100) begin tick(); n++; end
        chk("t1_run_done_seen", n < 100, 1);
        chk("t1_run_count", run_count, 1);
        tick();
        chk("t1_run_done_pulse", run_done, 0);
        chk("t1_fifo_level", fifo_level, 0);
        chk("t1_idle", busy, 0);

        // src write in IDLE, ignored during RUN
        cfg_src = 8'd2; cfg_src_we = 1'b1; tick(); cfg_src_we = 1'b0;
        chk("cfg_src_idle_2", src, 2);
        offer(8'd1, 8'd2, 32'hFFFF_FFFB, 10, 1);
        upd_valid = 1'b0;
        n = 0;
        while (container_reset && n < 20) begin tick(); n++; end
        chk("cfg_run_reached", n < 20, 1);
        cfg_src = 8'd7; cfg_src_we = 1'b1; tick(); cfg_src_we = 1'b0;
        chk("cfg_src_run_ignored", src, 2);
        n = 0;
        while (!run_done && n < 100) begin tick(); n++; end
        tick();
        chk("cfg_back_idle", busy, 0);
        cfg_src_we = 1'b1; tick(); cfg_src_we = 1'b0;
        chk("cfg_src_idle_7", src, 7);

        // watchdog aborts; next queued launches; err_clr and set-wins
        done_n = 1000;
        rc = int'(run_count);
        offer(8'd10, 8'd11, 32'd1, 20, 0);
        offer(8'd12, 8'd13, 32'd2, 20, 0);
        upd_valid = 1'b0;
        n = 0;
        while (!timeout_err && n < 100) begin tick(); n++; end
        chk("wd_abort_seen", n < 100, 1);
        chk("wd_run_count_kept", run_count, rc);
        chk("wd_no_run_done", run_done, 0);
        n = 0;
        while (container_reset && n < 20) begin tick(); n++; end
        chk("wd_next_launch", n < 20, 1);
        repeat (4) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("wd_err_clr", timeout_err, 0);
        repeat (14) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("wd_set_beats_clr", timeout_err, 1);
        chk("wd_abort_busy", busy, 1);
        tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("wd_err_clr2", timeout_err, 0);

        // done and watchdog limit coincide -> completes
        done_n = TIMEOUT;
        offer(8'd20, 8'd21, 32'd77, 20, 1);
        upd_valid = 1'b0;
        n = 0;
        while (!run_done && n < 100) begin tick(); n++; end
        chk("tie_complete", n < 100, 1);
        chk("tie_timeout_err", timeout_err, 0);
        chk("tie_run_count", run_count, rc + 1);
        tick();

        // fill to DEPTH, 9th update held until the first pop
        done_n = 1000;
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", upd_ready, 1);
            offer(IDX_W'(i + 1), IDX_W'(i + 2), WEIGHT_W'(1000 + i), 20, 0);
        end
        upd_src = 8'd99; upd_dst = 8'd98; upd_e = 32'd9999;
        chk("full_ready_low", upd_ready, 0);
        chk("full_level", fifo_level, 8);
        n = 0;
        while (!upd_ready && n < 100) begin tick(); n++; end
        chk("ninth_held_until_pop", (n >= 10) && (n < 100), 1);
        begin
            exp_t x;
            x.s = 8'd99; x.d = 8'd98; x.e = 32'd9999; x.len = 20; x.ok = 0;
            exp_q.push_back(x);
        end
        tick();
        upd_valid = 1'b0;
        n = 0;
        while ((fifo_level != 0 || busy) && n < 600) begin tick(); n++; end
        chk("fill_drained", n < 600, 1);
        chk("fill_all_issued", exp_q.size(), 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // async reset mid-run with entries queued
        offer(8'd30, 8'd31, 32'd3, 20, 0);
        offer(8'd32, 8'd33, 32'd4, 20, 0);
        offer(8'd34, 8'd35, 32'd5, 20, 0);
        upd_valid = 1'b0;
        n = 0;
        while (container_reset && n < 20) begin tick(); n++; end
        chk("ar_run_reached", n < 20, 1);
        chk("ar_queued", fifo_level, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_container_reset_async", container_reset, 1);
        chk("ar_busy_async", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) tick();
        chk("ar_fifo_level", fifo_level, 0);
        chk("ar_run_count", run_count, 0);
        chk("ar_no_launch", {busy, container_reset}, 2'b01);
        chk("ar_ready", upd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
